avalon_wait_ram: RTL and testbench
==================================

AVALON_WAIT_RAM -- requirements
Module: avalon_wait_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15: extra wait states inserted per access.
REQ-004 Parameter LOAD_AW, default 8: width of the preload word-index port.
REQ-005 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port address, input, 32: Avalon byte address.
REQ-008 Port read, input, 1: Avalon read request.
REQ-009 Port write, input, 1: Avalon write request.
REQ-010 Port writedata, input, 32: Avalon write data.
REQ-011 Port byteenable, input, 4: bit i enables lane bits [8i+7:8i].
REQ-012 Port waitrequest, output, 1: Avalon stall indication.
REQ-013 Port readdata, output, 32: registered read data.
REQ-014 Port load_en, input, 1: synchronous preload strobe.
REQ-015 Port load_addr, input, LOAD_AW: preload word index.
REQ-016 Port load_data, input, 32: preload word.
REQ-017 Port bus_error, output, 1: sticky protocol or address fault flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-019 waitrequest SHALL be high when (read|write) is asserted and state != ACK, and SHALL be low otherwise.
REQ-020 In IDLE with (read|write) and !load_en, the FSM SHALL go to ACK if WAIT_CYCLES==0, else go to WAIT with cnt=WAIT_CYCLES.
REQ-021 In WAIT, cnt SHALL decrement each cycle, and the FSM SHALL go to ACK on the edge where cnt==1.
REQ-022 A request SHALL therefore see waitrequest high for exactly WAIT_CYCLES+1 cycles, then low for exactly 1 cycle (ACK), after which the FSM returns to IDLE.
REQ-023 Read data SHALL be registered into readdata on the edge entering ACK and held until the next read.
REQ-024 A write SHALL commit on the edge leaving ACK, updating only the lanes enabled by byteenable; byteenable==0 is acknowledged as a no-op.
REQ-025 Word index SHALL be (address-BASE_ADDR)>>2; the access is in range iff address>=BASE_ADDR and index<DEPTH_WORDS.
REQ-026 An out-of-range read SHALL return 32'h0, an out-of-range write SHALL be dropped, and both SHALL still be acknowledged and set bus_error.
REQ-027 address[1:0]!=0 SHALL set bus_error; the access proceeds with bits [1:0] ignored.
REQ-028 read&write together SHALL set bus_error and be executed as a write only, with readdata unchanged.
REQ-029 If read and write both drop while in WAIT, the FSM SHALL return to IDLE with no access and set bus_error.
REQ-030 load_en SHALL write load_data to word load_addr on the edge (indices >= DEPTH_WORDS ignored), force waitrequest high, and freeze FSM state and cnt.
REQ-031 bus_error SHALL stay set until reset.

Reset
REQ-032 Reset SHALL force state=IDLE, cnt=0, readdata=32'h0 and bus_error=0 asynchronously.
REQ-033 Memory contents SHALL be unaffected by reset.
REQ-034 A reset during WAIT or ACK SHALL abort the access with no memory write.

Structure
REQ-035 Package avalon_ram_pkg SHALL hold the state enum (IDLE, WAIT, ACK) and the localparams WORD_BYTES=4 and MAX_WAIT=15.
REQ-036 Storage SHALL be one sub-module, ram_word_array: a single-port, DEPTH_WORDS x 32 array with per-byte write enable, shared by the preload and bus paths via a mux (preload has priority).

Verification
REQ-037 With WAIT_CYCLES=1, preload word 1=32'h24020069, then read address 32'h4 -> waitrequest high for 2 cycles, low for 1, and readdata=32'h24020069 in the ACK cycle.
REQ-038 With WAIT_CYCLES=0, write 32'hAABBCCDD to address 32'h8 with byteenable=4'b0101 over prior 32'h0, then read it back -> readdata=32'h00BB00DD, and each access stalls 1 cycle.
REQ-039 Read address 32'h400 with DEPTH_WORDS=256 -> acknowledged, readdata=32'h0, bus_error=1.
REQ-040 Assert read and write to address 32'h0 with writedata=32'h12345678 -> memory holds 32'h12345678, readdata unchanged, bus_error=1.
REQ-041 With WAIT_CYCLES=3, assert reset in the second WAIT cycle of a write to address 32'h0 -> word 0 unchanged, readdata=32'h0, state=IDLE.
REQ-042 With WAIT_CYCLES=2, pulse load_en for 2 cycles during a pending read -> waitrequest is extended by exactly 2 cycles and the read returns the newly loaded word.

Source files
------------

// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the wait-state Avalon RAM slave.
package avalon_ram_pkg;

    localparam int WORD_BYTES = 4;
    localparam int MAX_WAIT   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/ram_word_array.sv
// Single-port word array with per-byte write enables and asynchronous read.
module ram_word_array
    import avalon_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    // Contents are deliberately not reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with a fixed number of wait states, a preload port and a sticky fault flag.
module avalon_wait_ram
    import avalon_ram_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter int          LOAD_AW     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic [3:0]         byteenable,
    output logic               waitrequest,
    output logic [31:0]        readdata,
    input  logic               load_en,
    input  logic [LOAD_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    output logic               bus_error
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          WAIT_EFF  = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_EFF);
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        bus_error_q, bus_error_d;

    logic        req;
    logic [29:0] index;
    logic        in_range;
    logic        fault;
    logic [31:0] load_idx32;
    logic        load_ok;
    logic        enter_ack;
    logic        abort;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Address bits [1:0] never take part in decoding; misalignment only flags a fault.
    assign req        = read | write;
    assign index      = address[31:2] - BASE_ADDR[31:2];
    assign in_range   = (address[31:2] >= BASE_ADDR[31:2]) && ({2'b00, index} < DEPTH_U);
    assign fault      = !in_range || (address[1:0] != 2'b00) || (read && write);
    assign load_idx32 = 32'(load_addr);
    assign load_ok    = load_idx32 < DEPTH_U;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            readdata_q  <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // A preload cycle freezes the sequencer wherever it stands.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        abort     = 1'b0;
        if (!load_en) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_EFF == 0) begin
                            state_d   = ACK;
                            enter_ack = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                        abort   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d   = ACK;
                            enter_ack = 1'b1;
                        end
                    end
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        waitrequest = load_en || (req && (state_q != ACK));
        mem_addr    = load_en ? load_idx32[AW-1:0] : index[AW-1:0];
        mem_wdata   = load_en ? load_data : writedata;
        mem_we      = 4'h0;
        if (load_en) begin
            if (load_ok) begin
                mem_we = 4'hF;
            end
        end else if ((state_q == ACK) && write && in_range) begin
            mem_we = byteenable;
        end

        // Combined read+write is executed as a write only, so readdata holds.
        readdata_d = readdata_q;
        if (enter_ack && read && !write) begin
            readdata_d = in_range ? mem_rdata : 32'h0;
        end

        bus_error_d = bus_error_q || abort ||
                      ((state_q == IDLE) && req && !load_en && fault);
    end

    ram_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign readdata  = readdata_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench: four instances with WAIT_CYCLES 0..3 share one stimulus; each step checks the instance it targets.
module tb_avalon_wait_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic        waitreq [4];
    logic [31:0] rdata   [4];
    logic        berr    [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        avalon_wait_ram #(
            .DEPTH_WORDS (256),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_CYCLES (g),
            .LOAD_AW     (8)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .address     (address),
            .read        (read),
            .write       (write),
            .writedata   (writedata),
            .byteenable  (byteenable),
            .waitrequest (waitreq[g]),
            .readdata    (rdata[g]),
            .load_en     (load_en),
            .load_addr   (load_addr),
            .load_data   (load_data),
            .bus_error   (berr[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Holds a request on instance k until it drops waitrequest; optional 2-cycle preload from iteration ld_at.
    task automatic access(input string tag, input int k, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input int ld_at, input logic [7:0] ld_addr, input logic [31:0] ld_data,
                          output int stall, output logic [31:0] data);
        logic acked;
        acked      = 1'b0;
        stall      = 0;
        data       = 32'h0;
        address    = a;
        writedata  = wd;
        byteenable = be;
        read       = rd;
        write      = wr;
        for (int i = 0; i < 60; i++) begin
            load_en   = (ld_at >= 0) && (i >= ld_at) && (i < ld_at + 2);
            load_addr = ld_addr;
            load_data = ld_data;
            @(negedge clk);
            if (!waitreq[k]) begin
                acked = 1'b1;
                data  = rdata[k];
                break;
            end
            stall++;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
        check({tag, "_ack"}, 32'(acked), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          st;
        logic [31:0] d;
        reset = 1'b0; read = 1'b0; write = 1'b0; address = 32'h0; writedata = 32'h0;
        byteenable = 4'h0; load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0;

        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_berr",  32'(berr[k]), 32'd0);
            check("rst_wait",  32'(waitreq[k]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        preload(8'd0, 32'h1111_1111);
        preload(8'd1, 32'h2402_0069);
        preload(8'd2, 32'h0000_0000);
        preload(8'd3, 32'hAAAA_0003);

        // Preload with no request still stalls the bus.
        load_en = 1'b1; load_addr = 8'd4; load_data = 32'h0;
        @(negedge clk);
        check("load_wait", 32'(waitreq[0]), 32'd1);
        @(posedge clk); #1;
        load_en = 1'b0;

        // One wait state, preloaded word.
        do_reset();
        access("r037", 1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r037_stall", 32'(st), 32'd2);
        check("r037_data",  d, 32'h2402_0069);
        check("r037_berr",  32'(berr[1]), 32'd0);

        // Zero wait states, partial-lane write then read back.
        do_reset();
        access("w038", 0, 1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, -1, 8'd0, 32'h0, st, d);
        check("w038_stall", 32'(st), 32'd1);
        access("r038", 0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r038_stall", 32'(st), 32'd1);
        check("r038_data",  d, 32'h00BB_00DD);
        check("r038_berr",  32'(berr[0]), 32'd0);

        // Out-of-range read returns zero and flags a fault.
        do_reset();
        access("r039a", 1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r039a_data", d, 32'h2402_0069);
        access("r039", 1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r039_stall", 32'(st), 32'd2);
        check("r039_data",  d, 32'h0);
        check("r039_berr",  32'(berr[1]), 32'd1);

        // Read and write together: write wins, readdata holds.
        do_reset();
        access("r040a", 1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        access("rw040", 1, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("rw040_stall", 32'(st), 32'd2);
        check("rw040_hold",  d, 32'h2402_0069);
        check("rw040_after", rdata[1], 32'h2402_0069);
        check("rw040_berr",  32'(berr[1]), 32'd1);
        access("r040", 1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r040_data",  d, 32'h1234_5678);

        // Misaligned address: access proceeds on the word, fault flagged.
        do_reset();
        access("mis", 0, 1'b1, 1'b0, 32'h5, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("mis_stall", 32'(st), 32'd1);
        check("mis_data",  d, 32'h2402_0069);
        check("mis_berr",  32'(berr[0]), 32'd1);

        // Request withdrawn during WAIT aborts with a fault.
        do_reset();
        address = 32'h4; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        check("drop_berr", 32'(berr[2]), 32'd1);
        check("drop_wait", 32'(waitreq[2]), 32'd0);
        access("drop_r", 2, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("drop_r_stall", 32'(st), 32'd3);
        check("drop_r_data",  d, 32'h2402_0069);

        // Reset in the second WAIT cycle of a write aborts it.
        do_reset();
        preload(8'd0, 32'h1111_1111);
        access("r041a", 3, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r041a_stall", 32'(st), 32'd4);
        check("r041a_data",  d, 32'h2402_0069);
        address = 32'h0; writedata = 32'hDEAD_BEEF; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; write = 1'b0;
        #1;
        check("r041_rdata", rdata[3], 32'h0);
        check("r041_berr",  32'(berr[3]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        access("r041", 3, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, -1, 8'd0, 32'h0, st, d);
        check("r041_stall", 32'(st), 32'd4);
        check("r041_data",  d, 32'h1111_1111);

        // Two preload cycles during a pending read stretch the stall and update the word read.
        do_reset();
        access("r042", 2, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF, 1, 8'd3, 32'h5555_CAFE, st, d);
        check("r042_stall", 32'(st), 32'd5);
        check("r042_data",  d, 32'h5555_CAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
